adler32_stream: RTL and testbench
=================================

Name: adler32_stream

Overview:
- Parametrised, streaming successor to the single-byte Adler-32 engine.
- Accepts a byte count, then consumes BYTES_PER_BEAT bytes per clock over a valid/ready data interface.
- Supports seeded continuation, so a message can be split across several jobs.
- Presents the 32-bit checksum {B,A} on a held valid/ready output; sits between the DMA byte stream and the integrity-check register block.

Parameters:
- BYTES_PER_BEAT, 4, byte lanes per data beat (1, 2, 4 or 8); lane 0 = data[7:0] = earliest byte.
- MODULUS, 65521, modulus for A and B; must satisfy 256 < MODULUS < 65536.
- CNT_W, 32, width of the byte-count input.

Ports:
- clock  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- size  in  CNT_W  message length in bytes for this job
- seed  in  32  initial {B,A}, used when seed_en=1
- seed_en  in  1  1: start from seed; 0: start from A=1, B=0
- size_valid  in  1  size/seed/seed_en valid
- size_ready  out  1  job accepted when size_valid & size_ready
- data  in  8*BYTES_PER_BEAT  data beat
- data_valid  in  1  beat valid
- data_ready  out  1  beat accepted when data_valid & data_ready
- checksum  out  32  {B[15:0], A[15:0]}
- checksum_valid  out  1  result available
- checksum_ready  in  1  result consumed when checksum_valid & checksum_ready

Behaviour:
- Reset, asynchronous and immediate:
  - state=IDLE, A=1, B=0, remaining=0.
  - size_ready=0, data_ready=0, checksum_valid=0, checksum=32'h00000001.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - size_ready=1, other handshakes 0.
  - On size accept: A/B load from seed (seed_en=1) or 1/0; remaining loads from size.
  - Next state is RUN if size≠0, else DONE.
- RUN:
  - data_ready=1, size_ready=0.
  - Each accepted beat processes k = min(remaining, BYTES_PER_BEAT) lanes, in order lane 0..k-1: A=(A+d)%MODULUS, then B=(B+A)%MODULUS.
  - Unused upper lanes of the final partial beat are ignored.
  - remaining decrements by k.
  - When the accepted beat brings remaining to 0, the next state is DONE.
  - data_valid=0 stalls with no state change.
- Per-lane arithmetic:
  - A<MODULUS and d≤255, so A+d<2·MODULUS; one conditional subtract suffices. The same holds for B+A.
  - Intermediates are 17 bits.
  - The lane chain is combinational within one cycle. No multiply or divide.
- DONE:
  - checksum_valid=1, checksum={B,A}, both held stable until checksum_ready=1.
  - On consume: back to IDLE; checksum_valid drops the next cycle; checksum holds its last value.
- Latency: checksum_valid rises the cycle after the last beat is accepted. For size=0 it rises the cycle after the size accept, carrying the initial value.
- Seed use: a seed whose A or B ≥ MODULUS is used as-is; the result is correct only for reduced seeds. Software chains jobs by feeding the previous checksum back as seed.
- size_valid while busy is ignored; size_ready=0 outside IDLE.
- data_valid in IDLE or DONE is ignored; data_ready=0 there.
- Handshake rule: valid signals need not wait for ready. Ready signals depend only on state, never combinationally on valid.
- Reset asserted mid-job aborts immediately to the reset values; any partial result is discarded.

Test Plan:
- Reset, then release: checksum=0x00000001, all valid/ready low except size_ready=1 from the first cycle after release.
- BYTES_PER_BEAT=1, size=3, "abc" (0x61,0x62,0x63) with 1-cycle data_valid gaps → checksum 0x024D0127, checksum_valid exactly 1 cycle after the 3rd accept.
- BYTES_PER_BEAT=4, size=9, "Wikipedia" in 3 beats, garbage in the upper 3 lanes of beat 3 → 0x11E60398.
- size=1024, all bytes 0xFF (exercises modulo wrap of A and B) → 0x79A6FC2E.
- Seed continuation: job1 "Wiki" (size 4), then job2 "pedia" with seed=job1 result and seed_en=1 → 0x11E60398. size=0 with seed_en=0 → 0x00000001 one cycle after accept.
- Hold checksum_ready=0 for 5 cycles → checksum and valid stable; size_valid pulse during DONE is ignored. Assert rst mid-RUN → outputs at reset values the same cycle, next job computes correctly.

Source files
------------

// File: rtl/adler32_stream.sv
// Streaming Adler-32: accepts a job (size, optional seed), folds BYTES_PER_BEAT bytes
// per accepted beat into A/B, then holds {B,A} on a valid/ready result port.
module adler32_stream #(
  parameter int BYTES_PER_BEAT = 4,
  parameter int MODULUS        = 65521,
  parameter int CNT_W          = 32
) (
  input  logic                        clock,
  input  logic                        rst,
  input  logic [CNT_W-1:0]            size,
  input  logic [31:0]                 seed,
  input  logic                        seed_en,
  input  logic                        size_valid,
  output logic                        size_ready,
  input  logic [8*BYTES_PER_BEAT-1:0] data,
  input  logic                        data_valid,
  output logic                        data_ready,
  output logic [31:0]                 checksum,
  output logic                        checksum_valid,
  input  logic                        checksum_ready
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [16:0]      MOD17 = 17'(MODULUS);
  localparam logic [CNT_W-1:0] BPB_C = CNT_W'(BYTES_PER_BEAT);

  // Handshake semantics: a transfer happens on a rising clock edge where valid and
  // ready are both 1; valids may rise before ready, readies depend only on state.

  logic [1:0]       state_q, state_d;
  logic [15:0]      a_q, a_d;
  logic [15:0]      b_q, b_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [31:0]      sum_q, sum_d;
  logic [16:0]      a_lane, b_lane;

  // Held low while rst is asserted so nothing is accepted during reset.
  assign size_ready     = (state_q == ST_IDLE) && !rst;
  assign data_ready     = (state_q == ST_RUN);
  assign checksum_valid = (state_q == ST_DONE);
  assign checksum       = sum_q;

  // Lane chain: lanes at or beyond the remaining count are skipped.
  always_comb begin
    a_lane = {1'b0, a_q};
    b_lane = {1'b0, b_q};
    for (int i = 0; i < BYTES_PER_BEAT; i++) begin
      if (rem_q > CNT_W'(i)) begin
        a_lane = a_lane + {9'd0, data[8*i +: 8]};
        if (a_lane >= MOD17) a_lane = a_lane - MOD17;
        b_lane = b_lane + a_lane;
        if (b_lane >= MOD17) b_lane = b_lane - MOD17;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    rem_d   = rem_q;
    sum_d   = sum_q;
    case (state_q)
      ST_IDLE: begin
        if (size_valid) begin
          a_d   = seed_en ? seed[15:0]  : 16'd1;
          b_d   = seed_en ? seed[31:16] : 16'd0;
          rem_d = size;
          if (size == '0) begin
            state_d = ST_DONE;
            sum_d   = {b_d, a_d};
          end else begin
            state_d = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        if (data_valid) begin
          a_d = a_lane[15:0];
          b_d = b_lane[15:0];
          if (rem_q > BPB_C) begin
            rem_d = rem_q - BPB_C;
          end else begin
            rem_d   = '0;
            state_d = ST_DONE;
            sum_d   = {b_lane[15:0], a_lane[15:0]};
          end
        end
      end
      ST_DONE: begin
        if (checksum_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      a_q     <= 16'd1;
      b_q     <= 16'd0;
      rem_q   <= '0;
      sum_q   <= 32'h0000_0001;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      rem_q   <= rem_d;
      sum_q   <= sum_d;
    end
  end

endmodule

// File: tb/tb_adler32_stream.sv
// Bench for adler32_stream: one 1-byte/beat and one 4-byte/beat instance, selected
// per job; expected checksums are queued at job start and checked on result.
module tb_adler32_stream;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] size, seed, data;
  logic        seed_en, size_valid, data_valid, checksum_ready;
  logic        sel;

  logic        sr1, dr1, cv1, sr4, dr4, cv4;
  logic [31:0] cs1, cs4;
  logic        sr_m, dr_m, cv_m;
  logic [31:0] cs_m;

  logic [7:0]  msg[$];
  logic [31:0] exp_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;

  always #5 clk = ~clk;

  adler32_stream #(.BYTES_PER_BEAT(1)) u_dut1 (
    .clock(clk), .rst(rst), .size(size), .seed(seed), .seed_en(seed_en),
    .size_valid(size_valid & sel), .size_ready(sr1),
    .data(data[7:0]), .data_valid(data_valid & sel), .data_ready(dr1),
    .checksum(cs1), .checksum_valid(cv1), .checksum_ready(checksum_ready & sel)
  );

  adler32_stream #(.BYTES_PER_BEAT(4)) u_dut4 (
    .clock(clk), .rst(rst), .size(size), .seed(seed), .seed_en(seed_en),
    .size_valid(size_valid & ~sel), .size_ready(sr4),
    .data(data), .data_valid(data_valid & ~sel), .data_ready(dr4),
    .checksum(cs4), .checksum_valid(cv4), .checksum_ready(checksum_ready & ~sel)
  );

  assign sr_m = sel ? sr1 : sr4;
  assign dr_m = sel ? dr1 : dr4;
  assign cv_m = sel ? cv1 : cv4;
  assign cs_m = sel ? cs1 : cs4;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [31:0] sd, input logic se);
    int unsigned a, b;
    a = se ? 32'(sd[15:0])  : 1;
    b = se ? 32'(sd[31:16]) : 0;
    foreach (msg[i]) begin
      a = (a + 32'(msg[i])) % 65521;
      b = (b + a) % 65521;
    end
    return {b[15:0], a[15:0]};
  endfunction

  task automatic set_msg(input string s);
    msg.delete();
    for (int i = 0; i < s.len(); i++) msg.push_back(s[i]);
  endtask

  task automatic set_rand_msg(input int n);
    msg.delete();
    for (int i = 0; i < n; i++) msg.push_back(8'($urandom_range(0, 255)));
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic start_job(input logic [31:0] sz, input logic [31:0] sd, input logic se,
                           input logic [31:0] exp);
    int cyc = 0;
    size = sz; seed = sd; seed_en = se; size_valid = 1'b1;
    while (!sr_m && cyc < 50) begin @(negedge clk); cyc++; end
    if (cyc >= 50) check("size_ready_timeout", {31'd0, sr_m}, 32'd1);
    @(negedge clk);
    size_valid = 1'b0;
    exp_q.push_back(exp);
  endtask

  task automatic send(input int gap_mode, input int max_beats);
    int lanes = sel ? 1 : 4;
    int nb    = (msg.size() + lanes - 1) / lanes;
    int cyc;
    if (max_beats < nb) nb = max_beats;
    for (int bt = 0; bt < nb; bt++) begin
      int g = (gap_mode == 1) ? 1 : (gap_mode == 2) ? int'($urandom_range(0, 2)) : 0;
      repeat (g) begin data_valid = 1'b0; @(negedge clk); end
      data = $urandom;
      for (int l = 0; l < lanes; l++)
        if (bt * lanes + l < msg.size()) data[8*l +: 8] = msg[bt * lanes + l];
      data_valid = 1'b1;
      cyc = 0;
      while (!dr_m && cyc < 50) begin @(negedge clk); cyc++; end
      if (cyc >= 50) check("data_ready_timeout", {31'd0, dr_m}, 32'd1);
      @(negedge clk);
    end
    data_valid = 1'b0;
  endtask

  task automatic collect(input int hold, output logic [31:0] got);
    int cyc = 0;
    logic [31:0] exp;
    while (!cv_m && cyc < 200) begin @(negedge clk); cyc++; end
    if (cyc >= 200) check("checksum_valid_timeout", {31'd0, cv_m}, 32'd1);
    got = cs_m;
    for (int h = 0; h < hold; h++) begin
      checksum_ready = 1'b0;
      size_valid = (h == 2);
      size = 32'd5;
      @(negedge clk);
      size_valid = 1'b0;
      check("hold_valid", {31'd0, cv_m}, 32'd1);
      check("hold_sum", cs_m, got);
      check("hold_size_ready", {31'd0, sr_m}, 32'd0);
    end
    if (exp_q.size() == 0) begin
      check("queue_empty", 32'd0, 32'd1);
    end else begin
      exp = exp_q.pop_front();
      check("checksum", got, exp);
    end
    checksum_ready = 1'b1;
    @(negedge clk);
    checksum_ready = 1'b0;
    check("valid_drop", {31'd0, cv_m}, 32'd0);
    check("sum_held", cs_m, got);
    check("size_ready_back", {31'd0, sr_m}, 32'd1);
  endtask

  task automatic run_job(input int gap_mode, input logic [31:0] sd, input logic se,
                         input logic [31:0] exp, input int hold, output logic [31:0] got);
    start_job(32'(msg.size()), sd, se, exp);
    if (msg.size() != 0) send(gap_mode, 1 << 30);
    check("valid_latency", {31'd0, cv_m}, 32'd1);
    collect(hold, got);
  endtask

  initial begin
    logic [31:0] got, s1, sd;
    rst = 1'b1; sel = 1'b0; size = '0; seed = '0; seed_en = 1'b0;
    size_valid = 1'b0; data_valid = 1'b0; data = '0; checksum_ready = 1'b0;

    repeat (3) @(negedge clk);
    check("rst_checksum4", cs4, 32'h0000_0001);
    check("rst_checksum1", cs1, 32'h0000_0001);
    check("rst_ready_valid", {29'd0, sr4, dr4, cv4}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_size_ready", {30'd0, sr4, sr1}, 32'd3);
    check("post_rst_other", {28'd0, dr4, cv4, dr1, cv1}, 32'd0);
    check("post_rst_checksum", cs4, 32'h0000_0001);

    sel = 1'b1;
    set_msg("abc");
    run_job(1, 32'd0, 1'b0, 32'h024D_0127, 0, got);

    sel = 1'b0;
    set_msg("Wikipedia");
    run_job(2, 32'd0, 1'b0, 32'h11E6_0398, 0, got);

    msg.delete();
    for (int i = 0; i < 1024; i++) msg.push_back(8'hFF);
    run_job(0, 32'd0, 1'b0, 32'h79A6_FC2E, 0, got);

    set_msg("Wiki");
    run_job(2, 32'd0, 1'b0, model(32'd0, 1'b0), 0, s1);
    set_msg("pedia");
    run_job(2, s1, 1'b1, 32'h11E6_0398, 5, got);

    msg.delete();
    run_job(0, 32'hDEAD_BEEF, 1'b0, 32'h0000_0001, 0, got);

    set_rand_msg(20);
    start_job(32'd20, 32'd0, 1'b0, model(32'd0, 1'b0));
    send(0, 2);
    rst = 1'b1;
    #1;
    check("midrun_rst_checksum", cs4, 32'h0000_0001);
    check("midrun_rst_handshakes", {29'd0, sr4, dr4, cv4}, 32'd0);
    void'(exp_q.pop_back());
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("midrun_rst_size_ready", {31'd0, sr4}, 32'd1);

    for (int j = 0; j < 6; j++) begin
      sel = j[0];
      set_rand_msg(int'($urandom_range(1, 23)));
      sd  = {16'($urandom_range(0, 65520)), 16'($urandom_range(0, 65520))};
      run_job(2, sd, (j % 3) != 0, model(sd, (j % 3) != 0), (j == 3) ? 2 : 0, got);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
